// File: rtl/sar_avg_serializer.sv
// SAR result averager: accumulates 1/2/4/8 conversions per block and streams
// each averaged code MSB-first on a framed serial output, flagging overruns.
module sar_avg_serializer #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] code_in,
  input  logic             conv_done,
  input  logic [1:0]       avg_sel,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             sout,
  output logic             sframe,
  output logic             overrun
);

  localparam int unsigned AW = WIDTH + 3;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } ser_state_e;

  logic             conv_q;
  logic [AW-1:0]    acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;

  logic             sample_ev;
  logic [1:0]       sel_eff;
  logic [AW-1:0]    sum;
  logic [3:0]       cnt_inc;

  ser_state_e       state_q;
  logic [WIDTH-1:0] sh_q;
  logic [3:0]       bcnt_q;
  logic             ovr_q;
  logic             last_bit;
  logic             ovr_set;

  // Block size is taken from avg_sel only on the first sample of a block.
  always_comb begin
    sample_ev = conv_done & ~conv_q;
    sel_eff   = (cnt_q == '0) ? avg_sel : sel_q;
    sum       = acc_q + AW'(code_in);
    cnt_inc   = cnt_q + 4'd1;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    if (sample_ev) begin
      sel_d = sel_eff;
      if (cnt_inc == (4'd1 << sel_eff)) begin
        acc_d    = '0;
        cnt_d    = '0;
        result_d = WIDTH'(sum >> sel_eff);
        valid_d  = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      conv_q   <= conv_done;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    last_bit = (bcnt_q == 4'(WIDTH - 1));
    ovr_set  = valid_d && (state_q == S_SHIFT) && !last_bit;
  end

  // A result landing on the final shift cycle reloads without a gap;
  // one landing earlier leaves the current frame untouched and flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bcnt_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        if (valid_d) begin
          state_q <= S_SHIFT;
          sh_q    <= result_d;
          bcnt_q  <= '0;
        end
      end else if (last_bit) begin
        bcnt_q <= '0;
        if (valid_d) begin
          sh_q <= result_d;
        end else begin
          state_q <= S_IDLE;
          sh_q    <= '0;
        end
      end else begin
        sh_q   <= {sh_q[WIDTH-2:0], 1'b0};
        bcnt_q <= bcnt_q + 4'd1;
      end

      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign sframe       = (state_q == S_SHIFT);
  assign sout         = (state_q == S_SHIFT) & sh_q[WIDTH-1];
  assign overrun      = ovr_q;

endmodule

// File: doc/sar_avg_serializer.md
SAR_AVG_SERIALIZER -- requirements
Module: sar_avg_serializer

Interface
REQ-001 SHALL have parameter WIDTH, 12, width of the SAR conversion code.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port code_in  input  WIDTH  SAR conversion result, stable while conv_done is high.
REQ-005 SHALL have port conv_done  input  1  high-level SAR done indication; a conversion is counted on its 0->1 transition.
REQ-006 SHALL have port avg_sel  input  2  samples per average: 0->1, 1->2, 2->4, 3->8.
REQ-007 SHALL have port ovr_clr  input  1  synchronous clear of the sticky overrun flag.
REQ-008 SHALL have port result  output  WIDTH  latest averaged code.
REQ-009 SHALL have port result_valid  output  1  one-cycle pulse when result updates.
REQ-010 SHALL have port sout  output  1  serial data, MSB first.
REQ-011 SHALL have port sframe  output  1  high while sout carries valid bits.
REQ-012 SHALL have port overrun  output  1  sticky: a result arrived while the serializer was busy.

Function
REQ-013 SHALL register conv_done each cycle; sample event = conv_done high AND registered copy low; conv_done held high yields exactly one sample.
REQ-014 SHALL on a sample event add code_in (zero-extended) to a WIDTH+3-bit accumulator and increment a 4-bit sample counter.
REQ-015 SHALL latch avg_sel on the first sample of each block (counter 0); avg_sel changes mid-block SHALL be ignored until the next block.
REQ-016 SHALL, when the counter reaches 2^latched_sel, on that same edge write result = (accumulator incl. current sample) >> latched_sel (truncation), pulse result_valid, clear accumulator and counter.
REQ-017 SHALL give latency: sample event seen at edge T -> result/result_valid valid after edge T+1 (avg_sel=0).
REQ-018 Serializer SHALL be a two-state FSM IDLE/SHIFT with a WIDTH-bit shift register and 4-bit bit counter.
REQ-019 IDLE->SHIFT SHALL occur on the edge that asserts result_valid, loading the shift register with the new result.
REQ-020 In SHIFT, sframe SHALL be 1 and sout SHALL equal shift-register MSB; shift left one bit per clock; exactly WIDTH cycles, then IDLE.
REQ-021 In IDLE, sframe and sout SHALL be 0.
REQ-022 If a new result completes while SHIFT with bits remaining after this cycle, result SHALL update, the frame in progress SHALL continue unchanged, and overrun SHALL set.
REQ-023 If a new result completes on the last SHIFT cycle, the serializer SHALL reload and stay in SHIFT (back-to-back frame, no gap) with no overrun.
REQ-024 ovr_clr SHALL clear overrun; if a set condition occurs in the same cycle, set SHALL win.
REQ-025 Accumulator SHALL not overflow: 8 x (2^WIDTH-1) fits in WIDTH+3 bits.

Reset
REQ-026 rst_n low SHALL immediately force result=0, result_valid=0, sout=0, sframe=0, overrun=0, FSM IDLE, accumulator, counters, latched avg_sel and conv_done register to 0.
REQ-027 Reset mid-block or mid-frame SHALL discard partial accumulation and the frame; first conv_done rise after release starts a new block.
REQ-028 conv_done already high at reset release SHALL count as a sample event on the first active edge.

Verification
REQ-029 avg_sel=0, code_in=0xA5C, one conv_done rise -> result=0xA5C with one result_valid pulse one cycle later; sframe high 12 cycles; sout=1,0,1,0,0,1,0,1,1,1,0,0.
REQ-030 avg_sel=2, codes 0x100,0x101,0x102,0x104 -> single result_valid after 4th sample, result=0x101 (0x407>>2).
REQ-031 avg_sel=0, conv_done held high 20 cycles -> exactly one result_valid, one 12-bit frame.
REQ-032 avg_sel=0, second conv_done rise 5 cycles into a frame -> result updates, frame bits unchanged, overrun=1; ovr_clr pulse -> overrun=0.
REQ-033 avg_sel=3, eight samples of 0xFFF -> result=0xFFF, no wrap.
REQ-034 rst_n asserted after 2 of 4 samples (avg_sel=2) -> all outputs 0; four new samples of 0x010 -> result=0x010.
